gate_sweep: RTL



---
 rtl/gate_sweep.sv | 107 ++++++++++
 1 files changed

// File: rtl/gate_sweep.sv
// Exhaustive sweep of an N_IN-input combinational gate: walks every input pattern,
// compacting the 1-bit response into a MISR signature and a ones count.
module gate_sweep #(
    parameter int unsigned N_IN   = 10,
    parameter int unsigned SETTLE = 0,
    parameter int unsigned SIG_W  = 32,
    parameter logic [31:0] POLY   = 32'h04C11DB7,
    parameter logic [31:0] SEED   = 32'hFFFFFFFF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    output logic [N_IN-1:0]   gate_in,
    input  logic              gate_out,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic [N_IN:0]     ones_count
);

    localparam logic [SIG_W-1:0] PolyW   = POLY[SIG_W-1:0];
    localparam logic [SIG_W-1:0] SeedW   = SEED[SIG_W-1:0];
    localparam logic [3:0]       SettleW = 4'(SETTLE);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         hold_q, hold_d;
    logic [N_IN-1:0]    gate_in_q, gate_in_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [N_IN:0]      ones_q, ones_d;
    logic               sample;
    logic               last;
    logic [SIG_W-1:0]   misr_next;

    // gate_out is only trusted in the final cycle of each pattern's hold window
    assign sample = (state_q == StRun) && (hold_q == 4'd0);
    assign last   = &gate_in_q;

    assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                     ^ (sig_q[SIG_W-1] ? PolyW : '0)
                     ^ {{(SIG_W-1){1'b0}}, gate_out};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (sample && last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
    end

    always_comb begin
        hold_d    = hold_q;
        gate_in_d = gate_in_q;
        sig_d     = sig_q;
        ones_d    = ones_q;
        if (state_q == StIdle && start) begin
            gate_in_d = '0;
            hold_d    = SettleW;
            sig_d     = SeedW;
            ones_d    = '0;
        end else if (state_q == StRun) begin
            if (hold_q != 4'd0) begin
                hold_d = hold_q - 4'd1;
            end else begin
                sig_d     = misr_next;
                ones_d    = ones_q + {{N_IN{1'b0}}, gate_out};
                hold_d    = SettleW;
                gate_in_d = last ? '0 : gate_in_q + N_IN'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            hold_q    <= 4'd0;
            gate_in_q <= '0;
            sig_q     <= '0;
            ones_q    <= '0;
        end else begin
            hold_q    <= hold_d;
            gate_in_q <= gate_in_d;
            sig_q     <= sig_d;
            ones_q    <= ones_d;
        end
    end

    assign gate_in    = gate_in_q;
    assign signature  = sig_q;
    assign ones_count = ones_q;

endmodule
